// File: rtl/mux4_scan_ctrl_if.sv
// Scan bus between the mux scan controller and its user.
// start/ch_en/dwell/mux_out feed the controller; s1/s0/sample/valid/busy return.
interface mux4_scan_ctrl_if #(
  parameter int DWELL_W = 4
);
  logic               start;
  logic [3:0]         ch_en;
  logic [DWELL_W-1:0] dwell;
  logic               mux_out;
  logic               s1;
  logic               s0;
  logic [3:0]         sample;
  logic               valid;
  logic               busy;

  modport master (
    output start, ch_en, dwell, mux_out,
    input  s1, s0, sample, valid, busy
  );

  modport slave (
    input  start, ch_en, dwell, mux_out,
    output s1, s0, sample, valid, busy
  );
endinterface

// File: rtl/mux4_scan_ctrl.sv
// Scans enabled inputs of an external 4:1 mux, settling dwell+1 cycles each.
// Ports: clk, rst (sync, active high), bus (slave: start/ch_en/dwell/mux_out in; s1/s0/sample/valid/busy out).
module mux4_scan_ctrl #(
  parameter int DWELL_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  mux4_scan_ctrl_if.slave bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]         state;
  logic [1:0]         sel;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_q;
  logic [3:0]         mask_q;
  logic [3:0]         sample_q;
  logic [2:0]         first_hit;
  logic [2:0]         next_hit;

  // Lowest set bit of m at index >= from; bit 2 set means none.
  function automatic logic [2:0] first_from(
    input logic [3:0] m,
    input logic [2:0] from
  );
    logic [2:0] r;
    r = 3'b100;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (3'(i) >= from))
        r = {1'b0, 2'(i)};
    end
    return r;
  endfunction

  assign first_hit = first_from(bus.ch_en, 3'd0);
  assign next_hit  = first_from(mask_q, {1'b0, sel} + 3'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= '0;
      cnt      <= '0;
      dwell_q  <= '0;
      mask_q   <= '0;
      sample_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            mask_q   <= bus.ch_en;
            dwell_q  <= bus.dwell;
            sample_q <= '0;
            if (first_hit[2]) begin
              state <= DONE;
            end else begin
              state <= SETTLE;
              sel   <= first_hit[1:0];
              cnt   <= bus.dwell;
            end
          end
        end
        SETTLE: begin
          if (cnt == '0)
            state <= CAPTURE;
          else
            cnt <= cnt - 1'b1;
        end
        CAPTURE: begin
          sample_q[sel] <= bus.mux_out;
          // select moves only on the edge back into SETTLE
          if (next_hit[2]) begin
            state <= DONE;
          end else begin
            state <= SETTLE;
            sel   <= next_hit[1:0];
            cnt   <= dwell_q;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s1     = sel[1];
  assign bus.s0     = sel[0];
  assign bus.sample = sample_q;
  assign bus.valid  = (state == DONE);
  assign bus.busy   = (state != IDLE);
endmodule
